// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: segment count, segment
// bounds and the segment-to-stage mapping.
package csel_pkg;

  function automatic int csel_nblk(input int width, input int block);
    return (width + block - 1) / block;
  endfunction

  function automatic int csel_seg_lo(input int k, input int block);
    return k * block;
  endfunction

  // The top segment is narrower when WIDTH is not a multiple of BLOCK.
  function automatic int csel_seg_hi(input int k, input int width, input int block);
    int hi;
    hi = (k + 1) * block;
    if (hi > width) hi = width;
    return hi - 1;
  endfunction

  function automatic int csel_stage_first(input int s, input int nblk, input int stages);
    return (s * nblk) / stages;
  endfunction

  function automatic int csel_seg_stage(input int k, input int nblk, input int stages);
    int st;
    st = 0;
    for (int s = 0; s < stages; s++) begin
      if (csel_stage_first(s, nblk, stages) <= k) st = s;
    end
    return st;
  endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: carry-0 and carry-1 sums computed in parallel,
// then the incoming carry picks the pair.
module csel_segment
  import csel_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  logic [W:0] res0;
  logic [W:0] res1;

  assign res0 = {1'b0, a} + {1'b0, b};
  assign res1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};

  assign {co, sum} = ci ? res1 : res0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder with valid/ready on both sides.
// Optional PIPE_CSA_OVF_EN adds a registered signed-overflow output (ovf).
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = csel_nblk(WIDTH, BLOCK);
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] a_reg   [STAGES];
  logic [WIDTH-1:0] b_reg   [STAGES];
  logic [WIDTH-1:0] sum_reg [STAGES];
  logic [STAGES-1:0] carry_reg;
  logic [STAGES-1:0] valid_reg;

  logic [STAGES-1:0]            advance;
  logic [STAGES-1:0]            load;
  logic                         room;
  logic [STAGES-1:0][WIDTH-1:0] stage_a;
  logic [STAGES-1:0][WIDTH-1:0] stage_b;
  logic [STAGES-1:0][WIDTH-1:0] stage_sum_in;
  logic [STAGES-1:0][WIDTH-1:0] stage_sum_next;
  logic [STAGES-1:0]            stage_ci;
  logic [STAGES-1:0]            stage_co;
  logic [WIDTH-1:0]             seg_sum;
  logic [NBLK-1:0]              seg_co;

  // A stage moves on iff it is full and some stage above it is empty or the
  // consumer takes the head beat; written this way the chain has no loop.
  always_comb begin
    advance = '0;
    load    = '0;
    room    = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      advance[s] = valid_reg[s] && room;
      room       = room || !valid_reg[s];
    end
    load[0] = in_valid && in_ready;
    for (int s = 1; s < STAGES; s++) begin
      load[s] = advance[s-1];
    end
  end

  assign in_ready = !valid_reg[0] || advance[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int FIRST = csel_stage_first(gi, NBLK, STAGES);
    localparam int LASTS = csel_stage_first(gi + 1, NBLK, STAGES) - 1;
    localparam int LO    = csel_seg_lo(FIRST, BLOCK);
    localparam int HI    = csel_seg_hi(LASTS, WIDTH, BLOCK);
    localparam logic [WIDTH-1:0] MASK =
      ({WIDTH{1'b1}} >> (MSB - HI)) & ({WIDTH{1'b1}} << LO);

    if (gi == 0) begin : g_head
      assign stage_a[gi]      = a;
      assign stage_b[gi]      = b;
      assign stage_ci[gi]     = cin;
      assign stage_sum_in[gi] = '0;
    end else begin : g_body
      assign stage_a[gi]      = a_reg[gi-1];
      assign stage_b[gi]      = b_reg[gi-1];
      assign stage_ci[gi]     = carry_reg[gi-1];
      assign stage_sum_in[gi] = sum_reg[gi-1];
    end

    // Upper sum bits stay zero until their own stage resolves them.
    assign stage_sum_next[gi] = stage_sum_in[gi] | (seg_sum & MASK);
    assign stage_co[gi]       = seg_co[LASTS];
  end

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_seg
    localparam int LO = csel_seg_lo(gi, BLOCK);
    localparam int HI = csel_seg_hi(gi, WIDTH, BLOCK);
    localparam int ST = csel_seg_stage(gi, NBLK, STAGES);
    logic ci;

    if (gi == csel_stage_first(ST, NBLK, STAGES)) begin : g_ci_stage
      assign ci = stage_ci[ST];
    end else begin : g_ci_chain
      assign ci = seg_co[gi-1];
    end

    csel_segment #(.W(HI - LO + 1)) u_seg (
      .a   (stage_a[ST][HI:LO]),
      .b   (stage_b[ST][HI:LO]),
      .ci  (ci),
      .sum (seg_sum[HI:LO]),
      .co  (seg_co[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      carry_reg <= '0;
      for (int s = 0; s < STAGES; s++) begin
        a_reg[s]   <= '0;
        b_reg[s]   <= '0;
        sum_reg[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          valid_reg[s] <= 1'b1;
          a_reg[s]     <= stage_a[s];
          b_reg[s]     <= stage_b[s];
          sum_reg[s]   <= stage_sum_next[s];
          carry_reg[s] <= stage_co[s];
        end else if (advance[s]) begin
          valid_reg[s] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = valid_reg[LAST];
  assign sum       = sum_reg[LAST];
  assign cout      = carry_reg[LAST];

`ifdef PIPE_CSA_OVF_EN
  logic ovf_reg;

  // Carry into the MSB is recovered as a^b^sum at that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (load[LAST]) begin
      ovf_reg <= stage_a[LAST][MSB] ^ stage_b[LAST][MSB] ^
                 stage_sum_next[LAST][MSB] ^ stage_co[LAST];
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: four configurations side by side, each with a
// queue scoreboard fed by an arithmetic reference ({cout,sum} = a+b+cin).
module tb_pipelined_csel_adder;

  localparam int NDUT = 4;
  localparam int CW [NDUT] = '{32, 10, 16, 8};
  localparam int CB [NDUT] = '{4, 4, 3, 8};
  localparam int CS [NDUT] = '{2, 3, 4, 1};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDUT-1:0] in_valid_v;
  logic [NDUT-1:0] out_ready_v;
  logic [31:0]     a_r;
  logic [31:0]     b_r;
  logic            cin_r;
  bit              verbose;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int W = CW[gi];
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_g;
    longint       exp_q[$];
    int           out_cnt = 0;
    int           pend;

`ifdef PIPE_CSA_OVF_EN
    logic ovf_o;
    assign ovf_g = ovf_o;
`else
    assign ovf_g = 1'b0;
`endif

    pipelined_csel_adder #(.WIDTH(W), .BLOCK(CB[gi]), .STAGES(CS[gi])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready),
      .a         (a_r[W-1:0]),
      .b         (b_r[W-1:0]),
      .cin       (cin_r),
      .out_valid (out_valid),
      .out_ready (out_ready_v[gi]),
      .sum       (sum_o),
      .cout      (cout_o)
`ifdef PIPE_CSA_OVF_EN
      ,
      .ovf       (ovf_o)
`endif
    );

    assign pend = exp_q.size();

    always @(negedge clk or negedge rst_n) begin
      longint tot, e, got;
      logic [W-1:0] xa, xb, xs;
      logic xo;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready_v[gi]) begin
          out_cnt++;
          got = (longint'(ovf_g) << 33) | (longint'(cout_o) << 32) | longint'(sum_o);
          if (exp_q.size() == 0) begin
            check_eq($sformatf("dut%0d_spurious_out", gi), 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("dut%0d_result", gi), got, e);
          end
          if (verbose)
            $display("[TB] dut%0d out sum=%0h cout=%0b ovf=%0b", gi, sum_o, cout_o, ovf_g);
        end
        if (in_valid_v[gi] && in_ready) begin
          xa  = a_r[W-1:0];
          xb  = b_r[W-1:0];
          tot = longint'(xa) + longint'(xb) + longint'(cin_r);
          xs  = tot[W-1:0];
`ifdef PIPE_CSA_OVF_EN
          xo  = (xa[W-1] == xb[W-1]) && (xs[W-1] != xa[W-1]);
`else
          xo  = 1'b0;
`endif
          exp_q.push_back((longint'(xo) << 33) | (longint'(tot[W]) << 32) | longint'(xs));
        end
      end
    end
  end

  initial begin
    int i, cyc, start;
    bit saw_not_ready;
    longint snap, cur;

    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '1;
    a_r = '0; b_r = '0; cin_r = 1'b0;
    verbose = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", g_dut[0].out_valid, 0);
    check_eq("rst_sum", longint'(g_dut[0].sum_o), 0);
    check_eq("rst_cout", g_dut[0].cout_o, 0);
    check_eq("rst_in_ready", g_dut[0].in_ready, 1);
    check_eq("rst_in_ready_d1", g_dut[1].in_ready, 1);

    // Single beat, 2-cycle latency
    @(posedge clk); #1;
    a_r = 32'hFFFF_FFFF; b_r = 32'h1; cin_r = 1'b0; in_valid_v = 4'b0001;
    @(posedge clk); #1;
    in_valid_v = '0;
    @(negedge clk);
    check_eq("single_lat1_valid", g_dut[0].out_valid, 0);
    @(negedge clk);
    check_eq("single_valid", g_dut[0].out_valid, 1);
    check_eq("single_sum", longint'(g_dut[0].sum_o), 0);
    check_eq("single_cout", g_dut[0].cout_o, 1);
    check_eq("single_ovf", g_dut[0].ovf_g, 0);

    // Ragged width 10/4/3, signed overflow
    @(posedge clk); #1;
    a_r = 32'h1FF; b_r = 32'h1; cin_r = 1'b0; in_valid_v = 4'b0010;
    @(posedge clk); #1;
    in_valid_v = '0;
    repeat (2) begin
      @(negedge clk);
      check_eq("ragged_lat_valid", g_dut[1].out_valid, 0);
    end
    @(negedge clk);
    check_eq("ragged_valid", g_dut[1].out_valid, 1);
    check_eq("ragged_sum", longint'(g_dut[1].sum_o), 'h200);
    check_eq("ragged_cout", g_dut[1].cout_o, 0);
`ifdef PIPE_CSA_OVF_EN
    check_eq("ragged_ovf", g_dut[1].ovf_g, 1);
`endif

    // Backpressure: 8 beats, out_ready low on cycles 3..6
    repeat (4) @(posedge clk);
    #1;
    i = 0; cyc = 0; saw_not_ready = 1'b0; snap = 0;
    start = g_dut[0].out_cnt;
    while ((g_dut[0].out_cnt - start) < 8 && cyc < 60) begin
      in_valid_v[0]  = (i < 8);
      a_r            = i;
      b_r            = i * 3;
      cin_r          = i[0];
      out_ready_v[0] = !(cyc >= 3 && cyc <= 6);
      @(negedge clk);
      cur = (longint'(g_dut[0].out_valid) << 33) | (longint'(g_dut[0].cout_o) << 32) |
            longint'(g_dut[0].sum_o);
      if (!g_dut[0].in_ready) saw_not_ready = 1'b1;
      if (cyc == 3) begin
        check_eq("bp_stall_valid", g_dut[0].out_valid, 1);
        snap = cur;
      end else if (cyc >= 4 && cyc <= 6) begin
        check_eq("bp_stall_hold", cur, snap);
      end
      if (in_valid_v[0] && g_dut[0].in_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    check_eq("bp_out_count", g_dut[0].out_cnt - start, 8);
    check_eq("bp_accepted", i, 8);
    check_eq("bp_in_ready_dropped", saw_not_ready, 1);

    // Reset mid-flight on the 3-stage instance
    repeat (4) @(posedge clk);
    #1;
    a_r = 32'h5; b_r = 32'h6; in_valid_v = 4'b0010;
    @(posedge clk); #1;
    a_r = 32'h7;
    @(posedge clk); #1;
    in_valid_v = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", g_dut[1].out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("midrst_post_valid", g_dut[1].out_valid, 0);
      check_eq("midrst_post_sum", longint'(g_dut[1].sum_o), 0);
    end

    // Random traffic on all configurations
    verbose = 1'b0;
    repeat (6000) begin
      @(posedge clk); #1;
      a_r   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b_r   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      cin_r = 1'($urandom_range(0, 1));
      for (int k = 0; k < NDUT; k++) begin
        in_valid_v[k]  = ($urandom_range(0, 3) != 0);
        out_ready_v[k] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #1;
    in_valid_v  = '0;
    out_ready_v = '1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("drain_pending_d0", g_dut[0].pend, 0);
    check_eq("drain_pending_d1", g_dut[1].pend, 0);
    check_eq("drain_pending_d2", g_dut[2].pend, 0);
    check_eq("drain_pending_d3", g_dut[3].pend, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
